// File: rtl/traffic_pkg.sv
// Purpose : shared phase encoding, default phase durations and a duration lookup for the traffic sequencer.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_ALLRED = 2'd0,
      PH_GREEN  = 2'd1,
      PH_YELLOW = 2'd2
   } phase_e;

   localparam int unsigned DEF_GREEN_T  = 45;
   localparam int unsigned DEF_YELLOW_T = 5;
   localparam int unsigned DEF_ALLRED_T = 2;

   // Duration in ticks of a phase; the illegal encoding 3 is treated as all-red.
   function automatic int unsigned phase_dur(input phase_e      ph,
                                             input int unsigned green_t,
                                             input int unsigned yellow_t,
                                             input int unsigned allred_t);
      case (ph)
         PH_GREEN:  return green_t;
         PH_YELLOW: return yellow_t;
         default:   return allred_t;
      endcase
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_pick.sv
// Purpose : round-robin selector; returns the first requesting index after cur (wrapping, cur itself last).
// Latency : combinational.
// Backpressure: none; vld=0 when no request is present.
// Ports   : cur (current index), req (request mask) -> nxt (picked index), vld (any request).
module traffic_rr_pick #(
   parameter int NUM_DIR = 4,
   parameter int IDX_W   = 2
) (
   input  logic [IDX_W-1:0]   cur,
   input  logic [NUM_DIR-1:0] req,
   output logic [IDX_W-1:0]   nxt,
   output logic               vld
);

   logic [2*NUM_DIR-1:0] dbl;
   logic [NUM_DIR-1:0]   rot;

   always_comb begin
      dbl = {req, req};
      // rot[j] is the request of direction (cur+1+j) mod NUM_DIR, so j=NUM_DIR-1 is cur itself.
      rot = NUM_DIR'(dbl >> (int'(cur) + 1));
      nxt = '0;
      vld = 1'b0;
      // Scan downwards so the lowest j (nearest successor) is the last write and wins.
      for (int j = NUM_DIR - 1; j >= 0; j--) begin
         if (rot[j]) begin
            nxt = IDX_W'((int'(cur) + 1 + j) % NUM_DIR);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Purpose : N-direction round-robin traffic-light sequencer with internal GREEN/YELLOW/ALLRED countdown timers.
// Latency : all outputs registered; lamps/phase/remain change on the clock edge that consumes the expiring tick.
// Backpressure: hold freezes state and timer; ticks arriving while hold is high are dropped.
// Ports   : clk1, rst (sync, active-high), tick (1 Hz strobe), hold, car_present[NUM_DIR]
//           -> lr/ly/lg[NUM_DIR] lamps, cur_dir, phase (0 ALLRED,1 GREEN,2 YELLOW), remain, disp_en.
// Option  : define DEMAND_SKIP_EN to skip directions without car_present at all-red expiry.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int          NUM_DIR  = 2,
   parameter int          CNT_W    = 8,
   parameter int unsigned GREEN_T  = DEF_GREEN_T,
   parameter int unsigned YELLOW_T = DEF_YELLOW_T,
   parameter int unsigned ALLRED_T = DEF_ALLRED_T
) (
   input  logic                                              clk1,
   input  logic                                              rst,
   input  logic                                              tick,
   input  logic                                              hold,
   input  logic [NUM_DIR-1:0]                                car_present,
   output logic [NUM_DIR-1:0]                                lr,
   output logic [NUM_DIR-1:0]                                ly,
   output logic [NUM_DIR-1:0]                                lg,
   output logic [((NUM_DIR > 1) ? $clog2(NUM_DIR) : 1)-1:0] cur_dir,
   output logic [1:0]                                        phase,
   output logic [CNT_W-1:0]                                  remain,
   output logic                                              disp_en
);

   localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

   localparam logic [1:0] S_ALLRED = PH_ALLRED;
   localparam logic [1:0] S_GREEN  = PH_GREEN;
   localparam logic [1:0] S_YELLOW = PH_YELLOW;

   // Reload values are T-1; T may equal 2^CNT_W, so T-1 always fits after truncation.
   localparam logic [CNT_W-1:0] GR_LD = CNT_W'(phase_dur(PH_GREEN,  GREEN_T, YELLOW_T, ALLRED_T) - 32'd1);
   localparam logic [CNT_W-1:0] YL_LD = CNT_W'(phase_dur(PH_YELLOW, GREEN_T, YELLOW_T, ALLRED_T) - 32'd1);
   localparam logic [CNT_W-1:0] AR_LD = CNT_W'(phase_dur(PH_ALLRED, GREEN_T, YELLOW_T, ALLRED_T) - 32'd1);

   if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
      $error("traffic_phase_ctrl: NUM_DIR must be 2..8");
   end
   if (GREEN_T < 1 || GREEN_T > (32'd1 << CNT_W)) begin : g_bad_green
      $error("traffic_phase_ctrl: GREEN_T out of range");
   end
   if (YELLOW_T < 1 || YELLOW_T > (32'd1 << CNT_W)) begin : g_bad_yellow
      $error("traffic_phase_ctrl: YELLOW_T out of range");
   end
   if (ALLRED_T < 1 || ALLRED_T > (32'd1 << CNT_W)) begin : g_bad_allred
      $error("traffic_phase_ctrl: ALLRED_T out of range");
   end

   logic [1:0]         phase_q, phase_n;
   logic [DIR_W-1:0]   cur_dir_q, cur_dir_n, dir_inc;
   logic [CNT_W-1:0]   remain_q, remain_n;
   logic [NUM_DIR-1:0] lr_q, ly_q, lg_q, lr_n, ly_n, lg_n;
   logic               disp_en_q;
   logic               adv;

   assign adv = tick & ~hold;

   // Explicit wrap keeps non-power-of-two NUM_DIR from ever reaching an unused index.
   assign dir_inc = (cur_dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : cur_dir_q + DIR_W'(1);

`ifdef DEMAND_SKIP_EN
   logic [DIR_W-1:0] pick_nxt;
   logic             pick_vld;

   traffic_rr_pick #(
      .NUM_DIR (NUM_DIR),
      .IDX_W   (DIR_W)
   ) u_pick (
      .cur (cur_dir_q),
      .req (car_present),
      .nxt (pick_nxt),
      .vld (pick_vld)
   );
`else
   logic car_present_unused;
   assign car_present_unused = ^{car_present, dir_inc};
`endif

   always_comb begin
      phase_n   = phase_q;
      cur_dir_n = cur_dir_q;
      remain_n  = remain_q;
      if (adv) begin
         if (remain_q != '0) begin
            remain_n = remain_q - CNT_W'(1);
         end else begin
            case (phase_q)
               S_GREEN: begin
                  phase_n  = S_YELLOW;
                  remain_n = YL_LD;
               end
               S_YELLOW: begin
                  phase_n  = S_ALLRED;
                  remain_n = AR_LD;
               end
               default: begin
`ifdef DEMAND_SKIP_EN
                  // No demand anywhere: repeat the clearance interval on the same direction.
                  if (pick_vld) begin
                     phase_n   = S_GREEN;
                     cur_dir_n = pick_nxt;
                     remain_n  = GR_LD;
                  end else begin
                     phase_n  = S_ALLRED;
                     remain_n = AR_LD;
                  end
`else
                  phase_n   = S_GREEN;
                  cur_dir_n = dir_inc;
                  remain_n  = GR_LD;
`endif
               end
            endcase
         end
      end
   end

   // Lamps are decoded from the next state so they move in the same edge as phase/cur_dir.
   always_comb begin
      lg_n = '0;
      ly_n = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         if (cur_dir_n == DIR_W'(i)) begin
            lg_n[i] = (phase_n == S_GREEN);
            ly_n[i] = (phase_n == S_YELLOW);
         end
      end
      lr_n = ~(lg_n | ly_n);
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         phase_q   <= S_ALLRED;
         cur_dir_q <= DIR_W'(NUM_DIR - 1);
         remain_q  <= AR_LD;
         lr_q      <= '1;
         ly_q      <= '0;
         lg_q      <= '0;
         disp_en_q <= 1'b0;
      end else begin
         phase_q   <= phase_n;
         cur_dir_q <= cur_dir_n;
         remain_q  <= remain_n;
         lr_q      <= lr_n;
         ly_q      <= ly_n;
         lg_q      <= lg_n;
         disp_en_q <= 1'b1;
      end
   end

   assign phase   = phase_q;
   assign cur_dir = cur_dir_q;
   assign remain  = remain_q;
   assign lr      = lr_q;
   assign ly      = ly_q;
   assign lg      = lg_q;
   assign disp_en = disp_en_q;

endmodule
